// File: rtl/bc_io_pkg.sv
// ============================================================================
// Module   : bc_io_pkg
// Purpose  : Shared types and constants for the Basic Computer input port.
//            BC_INPUT_PARITY_EN adds the PARITY receiver state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bc_io_pkg;

  localparam int   INPR_W  = 8;
  localparam logic RX_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef BC_INPUT_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/bc_rx_sync.sv
// ============================================================================
// Module   : bc_rx_sync
// Purpose  : Two-flop synchronizer for the serial line plus falling-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bc_rx_sync
  import bc_io_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Reset to the idle level so a reset release never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RX_IDLE;
      sync2_q <= RX_IDLE;
      prev_q  <= RX_IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rx_s = sync2_q;
  assign fall = prev_q & ~sync2_q;

endmodule

`default_nettype wire

// File: rtl/bc_input_port.sv
// ============================================================================
// Module   : bc_input_port
// Purpose  : 8N1 serial receiver feeding INPR/FGI of the Basic Computer.
//            Define BC_INPUT_PARITY_EN for an even-parity bit after bit 7.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bc_input_port
  import bc_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              fgi_clr,
  input  logic              err_clr,
  output logic [INPR_W-1:0] inpr,
  output logic              FGI,
  output logic              frame_err,
  output logic              ovr_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT);

  logic rx_s, rx_fall;

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [INPR_W-1:0] shift_q, shift_d;
  logic              stop_bit_q, stop_bit_d;
  logic [INPR_W-1:0] inpr_q, inpr_d;
  logic              fgi_q, fgi_d;
  logic              frame_err_q, frame_err_d;
  logic              ovr_err_q, ovr_err_d;
  logic              busy_q, busy_d;
  logic              char_ok;
`ifdef BC_INPUT_PARITY_EN
  logic              par_ok_q, par_ok_d;
`endif

  bc_rx_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (rx_fall)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    stop_bit_d  = stop_bit_q;
    inpr_d      = inpr_q;
    fgi_d       = fgi_q;
    frame_err_d = frame_err_q;
    ovr_err_d   = ovr_err_q;
    busy_d      = (state_q != ST_IDLE);
`ifdef BC_INPUT_PARITY_EN
    par_ok_d    = par_ok_q;
    char_ok     = stop_bit_q & par_ok_q;
`else
    char_ok     = stop_bit_q;
`endif

    // Clears first so a coincident set below takes priority
    if (err_clr) begin
      frame_err_d = 1'b0;
      ovr_err_d   = 1'b0;
    end
    if (fgi_clr) fgi_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_fall) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[INPR_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef BC_INPUT_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = ST_PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef BC_INPUT_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          par_ok_d = ~(^shift_q ^ rx_s);
          state_d  = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        // Stop level is captured at mid-bit and acted on one cycle later
        if (cnt_q == CNT_DONE) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (!char_ok) begin
            frame_err_d = 1'b1;
          end else if (!fgi_q || fgi_clr) begin
            inpr_d = shift_q;
            fgi_d  = 1'b1;
          end else begin
            ovr_err_d = 1'b1;
          end
        end else begin
          if (cnt_q == CNT_LAST) stop_bit_d = rx_s;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= '0;
      stop_bit_q  <= 1'b0;
      inpr_q      <= '0;
      fgi_q       <= 1'b0;
      frame_err_q <= 1'b0;
      ovr_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BC_INPUT_PARITY_EN
      par_ok_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      stop_bit_q  <= stop_bit_d;
      inpr_q      <= inpr_d;
      fgi_q       <= fgi_d;
      frame_err_q <= frame_err_d;
      ovr_err_q   <= ovr_err_d;
      busy_q      <= busy_d;
`ifdef BC_INPUT_PARITY_EN
      par_ok_q    <= par_ok_d;
`endif
    end
  end

  assign inpr      = inpr_q;
  assign FGI       = fgi_q;
  assign frame_err = frame_err_q;
  assign ovr_err   = ovr_err_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_bc_input_port.sv
// ============================================================================
// Module   : tb_bc_input_port
// Purpose  : Directed self-checking bench for bc_input_port (8N1, 16 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bc_input_port;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       fgi_clr;
  logic       err_clr;
  logic [7:0] inpr;
  logic       fgi;
  logic       frame_err;
  logic       ovr_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic       fgi_hist [FRAME];
  logic       busy_hist[FRAME];

  bc_input_port #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .fgi_clr  (fgi_clr),
    .err_clr  (err_clr),
    .inpr     (inpr),
    .FGI      (fgi),
    .frame_err(frame_err),
    .ovr_err  (ovr_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Iteration c drives the line, then advances past edge c (edge 0 first sees the start bit)
  task automatic drive_frame(input logic [7:0] d, input logic stop_lvl, input int clr_at);
    for (int c = 0; c < FRAME; c++) begin
      int b;
      b = c / CPB;
      if (b == 0)      rx = 1'b0;
      else if (b <= 8) rx = d[b-1];
      else             rx = stop_lvl;
      fgi_clr = (c == clr_at);
      tick();
      fgi_hist[c]  = fgi;
      busy_hist[c] = busy;
    end
    fgi_clr = 1'b0;
    rx      = 1'b1;
  endtask

  task automatic pulse_fgi_clr();
    fgi_clr = 1'b1;
    tick();
    fgi_clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inpr"},  {24'd0, inpr}, 32'h00);
    check({tag, "_fgi"},   {31'd0, fgi}, 32'd0);
    check({tag, "_ferr"},  {31'd0, frame_err}, 32'd0);
    check({tag, "_ovr"},   {31'd0, ovr_err}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int busy_seen;
    int rise;

    rst_n   = 1'b0;
    rx      = 1'b1;
    fgi_clr = 1'b0;
    err_clr = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) tick();
    rst_n = 1'b1;

    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy !== 1'b0) busy_seen++;
    end
    check("idle_busy_never_high", busy_seen, 0);
    check("idle_fgi", {31'd0, fgi}, 32'd0);

    // 0xA5 with exact latency and busy timing
    exp_q.push_back(8'hA5);
    drive_frame(8'hA5, 1'b1, -1);
    rise = -1;
    for (int c = 0; c < FRAME; c++) if (fgi_hist[c] && rise < 0) rise = c;
    check("a5_fgi_latency", rise, 155);
    check("a5_busy_rise", {31'd0, busy_hist[3]}, 32'd1);
    check("a5_busy_before_done", {31'd0, busy_hist[155]}, 32'd1);
    check("a5_busy_fall", {31'd0, busy_hist[156]}, 32'd0);
    check("a5_inpr", {24'd0, inpr}, {24'd0, exp_q.pop_front()});
    check("a5_fgi", {31'd0, fgi}, 32'd1);

    // Short low glitch is a false start
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (30) tick();
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_fgi", {31'd0, fgi}, 32'd1);
    check("glitch_inpr", {24'd0, inpr}, 32'hA5);
    check("glitch_ferr", {31'd0, frame_err}, 32'd0);
    check("glitch_ovr", {31'd0, ovr_err}, 32'd0);

    pulse_fgi_clr();
    check("clr_fgi", {31'd0, fgi}, 32'd0);
    check("clr_keeps_inpr", {24'd0, inpr}, 32'hA5);

    // Overrun: second frame back-to-back while FGI still set
    exp_q.push_back(8'h3C);
    drive_frame(8'h3C, 1'b1, -1);
    check("ovr_first_inpr", {24'd0, inpr}, {24'd0, exp_q.pop_front()});
    drive_frame(8'h81, 1'b1, -1);
    check("ovr_inpr_kept", {24'd0, inpr}, 32'h3C);
    check("ovr_flag", {31'd0, ovr_err}, 32'd1);
    check("ovr_fgi", {31'd0, fgi}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovr_cleared", {31'd0, ovr_err}, 32'd0);
    pulse_fgi_clr();

    // fgi_clr coincident with the load of the second character
    exp_q.push_back(8'h3C);
    drive_frame(8'h3C, 1'b1, -1);
    check("coin_first_inpr", {24'd0, inpr}, {24'd0, exp_q.pop_front()});
    exp_q.push_back(8'h81);
    drive_frame(8'h81, 1'b1, 155);
    check("coin_inpr", {24'd0, inpr}, {24'd0, exp_q.pop_front()});
    check("coin_fgi_held", {31'd0, fgi_hist[155]}, 32'd1);
    check("coin_fgi", {31'd0, fgi}, 32'd1);
    check("coin_no_ovr", {31'd0, ovr_err}, 32'd0);

    // Framing error
    pulse_fgi_clr();
    drive_frame(8'h55, 1'b0, -1);
    repeat (4) tick();
    check("ferr_flag", {31'd0, frame_err}, 32'd1);
    check("ferr_fgi", {31'd0, fgi}, 32'd0);
    check("ferr_inpr", {24'd0, inpr}, 32'h81);
    check("ferr_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-frame
    rx = 1'b0;
    repeat (40) tick();
    check("mid_frame_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    rx    = 1'b1;
    repeat (20) tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_fgi", {31'd0, fgi}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
